// File: rtl/nativephy_loopback_sequencer.sv
// Runs one PHY serial-loopback test over CSR: enable, poll lock, dwell, recheck, disable.
// Strobes follow state with zero added latency; no backpressure, start is dropped while busy.
module nativephy_loopback_sequencer #(
  parameter logic [3:0]  CTRL_ADDR    = 4'd0,
  parameter logic [3:0]  STATUS_ADDR  = 4'd1,
  parameter logic [15:0] MAX_POLLS    = 16'd1000,
  parameter logic [31:0] DWELL_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic        aborted,
  output logic [15:0] poll_count
);

  // A zero dwell still spends one cycle in DWELL.
  localparam logic [31:0] DWELL_LAST = (DWELL_CYCLES == 32'd0) ? 32'd0 : DWELL_CYCLES - 32'd1;

  typedef enum logic [3:0] {
    IDLE, WR_EN, POLL_RD, POLL_WAIT, DWELL, FINAL_RD, FINAL_WAIT, WR_DIS, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] dwell_cnt;
  logic        locked;
  logic        can_abort;
  logic        abort_take;
  logic        poll_timeout;
  logic        unused_rdata_hi;

  assign locked          = (csr_readdata[1:0] == 2'b11);
  assign unused_rdata_hi = ^csr_readdata[31:2];
  assign can_abort       = (state == WR_EN) || (state == POLL_RD) || (state == POLL_WAIT) ||
                           (state == DWELL) || (state == FINAL_RD) || (state == FINAL_WAIT);
  assign abort_take      = abort && can_abort;
  assign poll_timeout    = (state == POLL_WAIT) && !locked && (poll_count >= MAX_POLLS);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  always_comb begin
    state_nxt     = state;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_address   = CTRL_ADDR;
    csr_writedata = 32'h0;
    case (state)
      IDLE:       if (start) state_nxt = WR_EN;
      WR_EN: begin
        csr_write     = 1'b1;
        csr_writedata = 32'h1;
        state_nxt     = POLL_RD;
      end
      POLL_RD: begin
        csr_read    = 1'b1;
        csr_address = STATUS_ADDR;
        state_nxt   = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (locked)            state_nxt = DWELL;
        else if (poll_timeout) state_nxt = WR_DIS;
        else                   state_nxt = POLL_RD;
      end
      DWELL:      if (dwell_cnt == DWELL_LAST) state_nxt = FINAL_RD;
      FINAL_RD: begin
        csr_read    = 1'b1;
        csr_address = STATUS_ADDR;
        state_nxt   = FINAL_WAIT;
      end
      FINAL_WAIT: state_nxt = WR_DIS;
      WR_DIS: begin
        csr_write = 1'b1;
        state_nxt = DONE;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    // Abort overrides any lock/timeout decision but leaves this cycle's strobe intact.
    if (abort_take) state_nxt = WR_DIS;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      dwell_cnt   <= 32'd0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      aborted     <= 1'b0;
      poll_count  <= 16'd0;
    end else begin
      state <= state_nxt;

      if (state == DWELL) dwell_cnt <= dwell_cnt + 32'd1;
      else                dwell_cnt <= 32'd0;

      if (state == IDLE && start) begin
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        aborted     <= 1'b0;
        poll_count  <= 16'd0;
      end

      if (state == POLL_RD && poll_count != 16'hFFFF) poll_count <= poll_count + 16'd1;

      if (abort_take) begin
        aborted <= 1'b1;
        pass    <= 1'b0;
      end else begin
        if (poll_timeout)          timeout_err <= 1'b1;
        if (state == FINAL_WAIT)   pass        <= locked;
      end
    end
  end

endmodule

// File: tb/tb_nativephy_loopback_sequencer.sv
// Bench for the loopback sequencer: a timeline model derived from the test's status script.
module tb_nativephy_loopback_sequencer;

  localparam int M = 8;
  localparam int D = 16;
  localparam int L = 64;
  localparam logic [3:0] CA = 4'd0;
  localparam logic [3:0] SA = 4'd1;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic        aborted;
  logic [15:0] poll_count;

  nativephy_loopback_sequencer #(
    .CTRL_ADDR(CA), .STATUS_ADDR(SA), .MAX_POLLS(16'(M)), .DWELL_CYCLES(32'(D))
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .aborted(aborted), .poll_count(poll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle activity, indexed by cycles since the start pulse.
  logic e_rd[L], e_wr[L], e_wd[L], e_busy[L], e_done[L], e_poll[L];
  int   e_len, e_done_c, e_wrdis_c, e_pc;
  logic e_pass, e_to, e_ab;
  logic [1:0] resp[$];

  int errors = 0;
  int checks = 0;
  int rc = 0;
  bit chk_en = 1'b0;
  logic [39:0] cmp_got, cmp_exp;
  logic [18:0] flg_got, flg_exp;

  task automatic chk(input string n, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic build(input int a);
    int k;
    for (int i = 0; i < L; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_wd[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_poll[i] = 0;
    end
    k = -1;
    for (int j = 0; j < M; j++) if (k < 0 && resp[j] == 2'b11) k = j;
    e_wr[1] = 1; e_wd[1] = 1;
    if (k >= 0) begin
      for (int j = 0; j <= k; j++) begin e_rd[2+2*j] = 1; e_poll[2+2*j] = 1; end
      e_rd[4+2*k+D] = 1;
      e_wrdis_c = 6 + 2*k + D;
      e_pass = (resp[k+1] == 2'b11);
      e_to = 0;
      e_pc = k + 1;
    end else begin
      for (int j = 0; j < M; j++) begin e_rd[2+2*j] = 1; e_poll[2+2*j] = 1; end
      e_wrdis_c = 2 + 2*M;
      e_pass = 0;
      e_to = 1;
      e_pc = M;
    end
    e_ab = 0;
    if (a >= 1 && a < e_wrdis_c) begin
      e_pc = 0;
      for (int i = 0; i <= a; i++) e_pc += int'(e_poll[i]);
      for (int i = a + 1; i < L; i++) begin e_rd[i] = 0; e_wr[i] = 0; e_wd[i] = 0; end
      e_wrdis_c = a + 1;
      e_pass = 0; e_to = 0; e_ab = 1;
    end
    e_wr[e_wrdis_c] = 1;
    e_done_c = e_wrdis_c + 1;
    e_done[e_done_c] = 1;
    for (int i = 1; i <= e_done_c; i++) e_busy[i] = 1;
    e_len = e_done_c + 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_got = {csr_read, csr_write, csr_address, csr_writedata, busy, done};
      cmp_exp = {e_rd[rc], e_wr[rc], (e_rd[rc] ? SA : CA), 31'd0, e_wd[rc], e_busy[rc], e_done[rc]};
      checks++;
      if (cmp_got !== cmp_exp) begin
        errors++;
        $display("FAIL cycle%0d outputs got=%h exp=%h", rc, cmp_got, cmp_exp);
      end
      flg_got = {pass, timeout_err, aborted, poll_count};
      if (rc == 1 || rc == e_done_c) begin
        flg_exp = (rc == 1) ? 19'd0 : {e_pass, e_to, e_ab, 16'(e_pc)};
        checks++;
        if (flg_got !== flg_exp) begin
          errors++;
          $display("FAIL cycle%0d flags got=%h exp=%h", rc, flg_got, flg_exp);
        end
      end
    end
  end

  task automatic run_test(input int a);
    logic rd;
    logic [31:0] r;
    int ri;
    build(a);
    ri = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; rc = 0; chk_en = 1'b1;
    for (int c = 1; c <= e_len; c++) begin
      @(negedge clk);
      rd = csr_read;
      @(posedge clk); #1;
      rc = c;
      start = (c <= e_done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (c == a) || (c >= e_wrdis_c && $urandom_range(0, 1) == 1);
      r = $urandom;
      if (rd && ri < resp.size()) begin
        csr_readdata = {r[31:2], resp[ri]};
        ri++;
      end else begin
        csr_readdata = r;
      end
    end
    @(negedge clk); #1;
    chk_en = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic set_script(input logic [1:0] first, input int n_first, input logic [1:0] rest);
    resp.delete();
    for (int j = 0; j <= M; j++) resp.push_back(j < n_first ? first : rest);
  endtask

  function automatic int count_rd();
    int s = 0;
    for (int i = 0; i < L; i++) s += int'(e_rd[i]);
    return s;
  endfunction

  function automatic int count_wr();
    int s = 0;
    for (int i = 0; i < L; i++) s += int'(e_wr[i]);
    return s;
  endfunction

  initial begin
    int a;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; csr_readdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {csr_read, csr_write, csr_address, csr_writedata, busy, done}, 40'd0);
    chk("reset_flags", {pass, timeout_err, aborted, poll_count}, 19'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Immediate lock, then final read also locked.
    set_script(2'b11, M + 1, 2'b11);
    run_test(-1);
    chk("imm_done_cycle", e_done_c, 23);
    chk("imm_final_rd20", e_rd[20], 1);
    chk("imm_wrdis22", e_wr[22], 1);
    chk("imm_model_pass_pc", {e_pass, 16'(e_pc)}, {1'b1, 16'd1});

    // Reset while idle must drop the held pass result.
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_reset_flags", {pass, timeout_err, aborted, poll_count}, 19'd0);

    // Late lock on the fifth poll.
    set_script(2'b01, 4, 2'b11);
    run_test(-1);
    chk("late_pc", e_pc, 5);
    chk("late_reads", count_rd(), 6);
    chk("late_writes", count_wr(), 2);

    // Never locks.
    set_script(2'b01, M + 1, 2'b01);
    run_test(-1);
    chk("to_done_cycle", e_done_c, 19);
    chk("to_reads", count_rd(), 8);
    chk("to_model_flags", {e_pass, e_to, 16'(e_pc)}, {1'b0, 1'b1, 16'd8});

    // Lock at first poll, lost by the final read.
    set_script(2'b11, 1, 2'b10);
    run_test(-1);
    chk("lost_model_pass_to", {e_pass, e_to}, 2'b00);

    // Abort in DWELL at cycle 10.
    set_script(2'b11, M + 1, 2'b11);
    run_test(10);
    chk("abort_wrdis_done", {8'(e_wrdis_c), 8'(e_done_c)}, {8'd11, 8'd12});
    chk("abort_model_flags", {e_ab, e_pass}, 2'b10);

    // Reset during POLL_WAIT: back to idle with no disable write.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b0; csr_readdata = 32'h3;
    @(negedge clk);
    chk("pre_reset_pc", poll_count, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {csr_read, csr_write, csr_address, csr_writedata, busy, done}, 40'd0);
    chk("midreset_flags", {pass, timeout_err, aborted, poll_count}, 19'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midreset_quiet", {csr_read, csr_write, busy}, 3'b000);
    end

    // Randomized scripts with occasional aborts.
    for (int t = 0; t < 40; t++) begin
      resp.delete();
      for (int j = 0; j <= M; j++)
        resp.push_back(($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      build(-1);
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, e_wrdis_c + 1)) : -1;
      run_test(a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
